// File: rtl/stream_demux_pkg.sv
// Shared route constants for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one select-tagged input stream and two output streams.
interface stream_demux_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    // Producer/consumer side: drives the input stream and the output ready lines.
    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );

endinterface

// File: rtl/stream_demux_fifo.sv
// Small synchronous FIFO (power-of-2 depth) used as the per-output buffer of stream_demux.
module demux_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A full FIFO never takes a push, even if it is popping in the same cycle.
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= only; the comb block above uses = for its temporaries.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the storage is reset too, because the head word is the visible x_data and must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer: routes each input word to output A or B by in_sel,
// with an independent FIFO per output and per-output accepted-word counters.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    stream_demux_if.slave    bus,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);

    logic             a_full, a_empty;
    logic             b_full, b_empty;
    logic [WIDTH-1:0] a_head, b_head;
    logic             sel_full;
    logic             in_ready;
    logic             accept;
    logic             push_a, push_b;
    logic             pop_a,  pop_b;

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        sel_full = (bus.in_sel == SEL_B) ? b_full : a_full;
        in_ready = ~rst & ~sel_full;
        accept   = bus.in_valid & in_ready;
        push_a   = accept & (bus.in_sel == SEL_A);
        push_b   = accept & (bus.in_sel == SEL_B);
        pop_a    = ~a_empty & bus.a_ready;
        pop_b    = ~b_empty & bus.b_ready;

        // Counters wrap silently at 2**CNT_W.
        cnt_a_d = push_a ? cnt_a_q + CNT_STEP : cnt_a_q;
        cnt_b_d = push_b ? cnt_b_q + CNT_STEP : cnt_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .push_data (bus.in_data),
        .pop       (pop_a),
        .full      (a_full),
        .empty     (a_empty),
        .head      (a_head)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .push_data (bus.in_data),
        .pop       (pop_b),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_head)
    );

    assign bus.in_ready = in_ready;
    assign bus.a_data   = a_head;
    assign bus.a_valid  = ~a_empty;
    assign bus.b_data   = b_head;
    assign bus.b_valid  = ~b_empty;
    assign cnt_a        = cnt_a_q;
    assign cnt_b        = cnt_b_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (DEPTH=2, CNT_W=4 so counter wrap is reachable).
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    stream_demux_if #(.WIDTH(8)) bus ();

    stream_demux #(
        .WIDTH (8),
        .DEPTH (2),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic sel, input logic [7:0] data);
        bus.in_valid = valid;
        bus.in_sel   = sel;
        bus.in_data  = data;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        drive(1'b1, 1'b0, 8'hAA);

        // Reset held two edges with a word offered.
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_a_valid",  bus.a_valid,  0);
        check("rst_b_valid",  bus.b_valid,  0);
        check("rst_cnt_a",    cnt_a,        0);
        check("rst_cnt_b",    cnt_b,        0);
        check("rst_a_data",   bus.a_data,   0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);

        // Routing.
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h11);
        check("route_in_ready", bus.in_ready, 1);
        tick();
        drive(1'b1, 1'b1, 8'h22);
        check("route_a_valid", bus.a_valid, 1);
        check("route_a_data",  bus.a_data,  8'h11);
        check("route_b_idle",  bus.b_valid, 0);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check("route_b_valid", bus.b_valid, 1);
        check("route_b_data",  bus.b_data,  8'h22);
        check("route_a_drain", bus.a_valid, 0);
        check("route_cnt_a",   cnt_a,       1);
        check("route_cnt_b",   cnt_b,       1);
        tick();
        check("route_b_drain", bus.b_valid, 0);

        // Backpressure on A; B still flows.
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h31);
        tick();
        drive(1'b1, 1'b0, 8'h32);
        tick();
        drive(1'b1, 1'b0, 8'h33);
        check("bp_full_stall", bus.in_ready, 0);
        tick();
        check("bp_a_hold_valid", bus.a_valid, 1);
        check("bp_a_hold_data",  bus.a_data,  8'h31);
        check("bp_still_stall",  bus.in_ready, 0);
        drive(1'b1, 1'b1, 8'h44);
        check("bp_b_ready", bus.in_ready, 1);
        tick();
        check("bp_b_data", bus.b_data, 8'h44);
        check("bp_cnt_a",  cnt_a,      3);

        // A full with consumer ready: pop this cycle, push lands next cycle.
        bus.a_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h33);
        check("fpp_no_pass", bus.in_ready, 0);
        tick();
        check("fpp_ready_after_pop", bus.in_ready, 1);
        check("fpp_a_data_2nd",      bus.a_data,   8'h32);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check("fpp_a_data_3rd", bus.a_data,  8'h33);
        check("fpp_a_valid",    bus.a_valid, 1);
        tick();
        check("fpp_a_empty", bus.a_valid, 0);
        check("fpp_cnt_a",   cnt_a,       4);
        check("fpp_cnt_b",   cnt_b,       2);
        bus.b_ready = 1'b1;
        tick();
        check("fpp_b_empty", bus.b_valid, 0);

        // Reset while A holds two words.
        bus.a_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h55);
        tick();
        drive(1'b1, 1'b0, 8'h66);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check("mid_a_loaded", bus.a_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_a_valid", bus.a_valid, 0);
        check("mid_a_data",  bus.a_data,  0);
        check("mid_cnt_a",   cnt_a,       0);
        check("mid_cnt_b",   cnt_b,       0);
        bus.a_ready = 1'b1;
        tick();
        tick();
        check("mid_no_replay", bus.a_valid, 0);
        drive(1'b1, 1'b0, 8'h77);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check("mid_new_word", bus.a_data, 8'h77);
        check("mid_cnt_a_1",  cnt_a,      1);

        // 17 back-to-back words to B: pointers wrap, order kept, cnt_b wraps 16 -> 0 -> 1.
        bus.b_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 8'h80 + 8'(i));
            tick();
            check($sformatf("wrap_b_data_%0d", i), bus.b_data, 8'h80 + 8'(i));
        end
        drive(1'b0, 1'b0, 8'h00);
        check("wrap_cnt_b",   cnt_b,       1);
        check("wrap_cnt_a",   cnt_a,       1);
        tick();
        check("wrap_b_empty", bus.b_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
